// File: rtl/dlfloat_operand_loader.sv
// -----------------------------------------------------------------------------
// dlfloat_operand_loader
//
// Purpose:
//   Collects a serial stream of DLFloat16 operand words into (A, B) pairs.
//   Words arrive A first, then B. Each completed pair is pushed into a small
//   first-word-fall-through FIFO that feeds a MAC. Every pair is tagged:
//     clr  - first pair of a new accumulation
//     last - final pair of an accumulation
//   Operand values are passed through bit-exact.
//
// Parameters:
//   DEPTH - number of operand pairs the FIFO holds (power of 2, >= 2)
//
// Optional feature macro:
//   DLF_ZERO_SKIP_EN - when defined, a completed pair that has a zero operand
//                      and last=0 is dropped rather than pushed. A zero pair
//                      with last=1 is still pushed so that the accumulation
//                      boundary survives.
//
// Ports:
//   clk        in   1         single clock, rising edge
//   rst_n      in   1         asynchronous active-low reset
//   in_data    in   16        DLFloat16 operand word (A, then B)
//   in_valid   in   1         in_data valid this cycle
//   in_ready   out  1         word accepted when in_valid && in_ready
//   in_last    in   1         sampled with a B word: last pair of a dot product
//   out_a      out  16        head pair, operand A (0 when empty)
//   out_b      out  16        head pair, operand B (0 when empty)
//   out_valid  out  1         a pair is presented
//   out_ready  in   1         MAC consumes the presented pair
//   out_clr    out  1         head pair starts a new accumulation
//   out_last   out  1         head pair ends an accumulation
//   level      out  AW+1      number of pairs stored
//   err_odd    out  1         sticky: in_last seen with an A word
// -----------------------------------------------------------------------------
module dlfloat_operand_loader #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [15:0]                in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_last,
    output logic [15:0]                out_a,
    output logic [15:0]                out_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_clr,
    output logic                       out_last,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       err_odd
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    typedef enum logic {
        S_A = 1'b0,
        S_B = 1'b1
    } phase_t;

    phase_t          state_r;
    phase_t          state_nxt_s;
    logic [15:0]     hold_r;
    logic            clr_pend_r;
    logic            err_odd_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     level_r;

    logic [15:0]     mem_a_r    [DEPTH];
    logic [15:0]     mem_b_r    [DEPTH];
    logic            mem_last_r [DEPTH];
    logic            mem_clr_r  [DEPTH];

    logic            full_s;
    logic            in_ready_s;
    logic            accept_s;
    logic            load_hold_s;
    logic            pair_done_s;
    logic            odd_s;
    logic            push_s;
    logic            pop_s;
    logic            out_valid_s;

    // Fullness comes from the registered level only: a pop in the same cycle
    // does not open a slot, which keeps in_ready free of out_ready paths.
    assign full_s      = (level_r == LVL_FULL);
    assign out_valid_s = (level_r != {(AW + 1){1'b0}});
    assign accept_s    = in_valid && in_ready_s;
    assign pop_s       = out_valid_s && out_ready;

    // Input ready: A words are always taken (they only fill the hold register).
    always_comb begin
        in_ready_s = 1'b1;
        case (state_r)
            S_A:     in_ready_s = 1'b1;
            S_B:     in_ready_s = !full_s;
            default: in_ready_s = 1'b1;
        endcase
    end

    // Phase FSM next state and per-word actions.
    always_comb begin
        state_nxt_s = state_r;
        load_hold_s = 1'b0;
        pair_done_s = 1'b0;
        odd_s       = 1'b0;
        case (state_r)
            S_A: begin
                if (accept_s) begin
                    state_nxt_s = S_B;
                    load_hold_s = 1'b1;
                    odd_s       = in_last;
                end else begin
                    state_nxt_s = S_A;
                end
            end
            S_B: begin
                if (accept_s) begin
                    state_nxt_s = S_A;
                    pair_done_s = 1'b1;
                end else begin
                    state_nxt_s = S_B;
                end
            end
            default: begin
                state_nxt_s = S_A;
            end
        endcase
    end

`ifdef DLF_ZERO_SKIP_EN
    // Drop zero-operand pairs unless they carry the accumulation boundary.
    assign push_s = pair_done_s &&
                    (in_last || ((hold_r != 16'h0000) && (in_data != 16'h0000)));
`else
    // Every completed pair goes into the FIFO.
    assign push_s = pair_done_s;
`endif

    // Phase state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_A;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Hold register for the A word, clear-pending tag and sticky odd error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r     <= 16'h0000;
            clr_pend_r <= 1'b1;
            err_odd_r  <= 1'b0;
        end else begin
            if (load_hold_s) begin
                hold_r <= in_data;
            end
            // The pair after a last pair opens a new accumulation.
            if (push_s) begin
                clr_pend_r <= in_last;
            end
            if (odd_s) begin
                err_odd_r <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {(AW + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + {{AW{1'b0}}, 1'b1};
                2'b01:   level_r <= level_r - {{AW{1'b0}}, 1'b1};
                default: level_r <= level_r;
            endcase
        end
    end

    // FIFO storage; cleared on reset so no stale pair can ever surface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a_r[i]    <= 16'h0000;
                mem_b_r[i]    <= 16'h0000;
                mem_last_r[i] <= 1'b0;
                mem_clr_r[i]  <= 1'b0;
            end
        end else if (push_s) begin
            mem_a_r[wr_ptr_r]    <= hold_r;
            mem_b_r[wr_ptr_r]    <= in_data;
            mem_last_r[wr_ptr_r] <= in_last;
            mem_clr_r[wr_ptr_r]  <= clr_pend_r;
        end
    end

    // Head-of-FIFO presentation, forced to zero while empty.
    always_comb begin
        out_a    = 16'h0000;
        out_b    = 16'h0000;
        out_clr  = 1'b0;
        out_last = 1'b0;
        if (out_valid_s) begin
            out_a    = mem_a_r[rd_ptr_r];
            out_b    = mem_b_r[rd_ptr_r];
            out_clr  = mem_clr_r[rd_ptr_r];
            out_last = mem_last_r[rd_ptr_r];
        end else begin
            out_a    = 16'h0000;
            out_b    = 16'h0000;
            out_clr  = 1'b0;
            out_last = 1'b0;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign level     = level_r;
    assign err_odd   = err_odd_r;

endmodule

// File: tb/tb_dlfloat_operand_loader.sv
module tb_dlfloat_operand_loader;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic        out_valid;
    logic        out_ready;
    logic        out_clr;
    logic        out_last;
    logic [2:0]  level;
    logic        err_odd;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    dlfloat_operand_loader #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_clr   (out_clr),
        .out_last  (out_last),
        .level     (level),
        .err_odd   (err_odd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Present one word and wait (bounded) for it to be accepted; returns at edge+1.
    task automatic send(input logic [15:0] d, input logic l);
        int n;
        n = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 16'h0000;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int  idx;
        logic acc;
        logic pv;

        rst_n     = 1'b0;
        in_data   = 16'h0000;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        // Reset state
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_a",     32'(out_a),     32'd0);
        chk("rst_out_b",     32'(out_b),     32'd0);
        chk("rst_out_clr",   32'(out_clr),   32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_level",     32'(level),     32'd0);
        chk("rst_err_odd",   32'(err_odd),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);

        // Basic pair
        out_ready = 1'b1;
        send(16'h3E00, 1'b0);
        chk("basic_lvl_after_a", 32'(level), 32'd0);
        send(16'h4000, 1'b1);
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_a",     32'(out_a),     32'h3E00);
        chk("basic_b",     32'(out_b),     32'h4000);
        chk("basic_clr",   32'(out_clr),   32'd1);
        chk("basic_last",  32'(out_last),  32'd1);
        chk("basic_level", 32'(level),     32'd1);
        tick(1);
        chk("basic_popped_lvl", 32'(level), 32'd0);
        chk("basic_empty_a",    32'(out_a), 32'd0);

        // Fill and backpressure: 4 pairs + A of the 5th
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(16'h1000 + 16'(i), 1'b0);
            send(16'h2000 + 16'(i), 1'b0);
        end
        send(16'h1004, 1'b0);
        chk("fill_level", 32'(level), 32'd4);
        in_data  = 16'h2004;
        in_last  = 1'b0;
        in_valid = 1'b1;
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        tick(2);
        chk("fill_hold_ready", 32'(in_ready), 32'd0);
        chk("fill_hold_level", 32'(level),    32'd4);
        chk("fill_hold_a",     32'(out_a),    32'h1000);
        out_ready = 1'b1;
        idx = 0;
        for (int c = 0; c < 20 && idx < 5; c++) begin
            if (out_valid) begin
                chk("drain_a",   32'(out_a),   32'h1000 + 32'(idx));
                chk("drain_b",   32'(out_b),   32'h2000 + 32'(idx));
                chk("drain_clr", 32'(out_clr), (idx == 0) ? 32'd1 : 32'd0);
            end
            acc = in_valid && in_ready;
            pv  = out_valid && out_ready;
            @(posedge clk); #1;
            if (pv)  idx++;
            if (acc) in_valid = 1'b0;
        end
        chk("drain_count", 32'(idx),      32'd5);
        chk("drain_level", 32'(level),    32'd0);
        chk("drain_inval", 32'(in_valid), 32'd0);

        // Simultaneous push and pop at level 2
        out_ready = 1'b0;
        send(16'h5000, 1'b0);
        send(16'h6000, 1'b0);
        send(16'h5001, 1'b0);
        send(16'h6001, 1'b0);
        send(16'h5002, 1'b0);
        chk("pp_level_before", 32'(level), 32'd2);
        in_data   = 16'h6002;
        in_last   = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick(1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("pp_level_same", 32'(level), 32'd2);
        chk("pp_head_a",     32'(out_a), 32'h5001);
        tick(2);
        chk("pp_level_drained", 32'(level), 32'd0);

        // Clear tagging: last = 0,0,1 then 0
        out_ready = 1'b0;
        send(16'h0A01, 1'b0); send(16'h0B01, 1'b0);
        send(16'h0A02, 1'b0); send(16'h0B02, 1'b0);
        send(16'h0A03, 1'b0); send(16'h0B03, 1'b1);
        send(16'h0A04, 1'b0); send(16'h0B04, 1'b0);
        out_ready = 1'b1;
        chk("tag0_clr", 32'(out_clr), 32'd1); chk("tag0_last", 32'(out_last), 32'd0);
        tick(1);
        chk("tag1_clr", 32'(out_clr), 32'd0); chk("tag1_last", 32'(out_last), 32'd0);
        tick(1);
        chk("tag2_clr", 32'(out_clr), 32'd0); chk("tag2_last", 32'(out_last), 32'd1);
        tick(1);
        chk("tag3_clr", 32'(out_clr), 32'd1); chk("tag3_last", 32'(out_last), 32'd0);
        chk("tag3_b",   32'(out_b),   32'h0B04);
        tick(1);
        chk("tag_empty", 32'(out_valid), 32'd0);

        // Odd last on an A word, then reset mid-pair
        send(16'h7777, 1'b1);
        chk("odd_err",   32'(err_odd), 32'd1);
        chk("odd_level", 32'(level),   32'd0);
        tick(2);
        chk("odd_sticky", 32'(err_odd), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("odd_rst_err",   32'(err_odd),  32'd0);
        chk("odd_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        send(16'h1111, 1'b0);
        chk("post_rst_a_only", 32'(level), 32'd0);
        send(16'h2222, 1'b1);
        chk("post_rst_a",    32'(out_a),    32'h1111);
        chk("post_rst_b",    32'(out_b),    32'h2222);
        chk("post_rst_clr",  32'(out_clr),  32'd1);
        chk("post_rst_last", 32'(out_last), 32'd1);
        tick(1);
        chk("post_rst_pop", 32'(level), 32'd0);

        // Zero operand pairs
        out_ready = 1'b0;
        send(16'h0000, 1'b0);
        send(16'h4000, 1'b0);
`ifdef DLF_ZERO_SKIP_EN
        chk("zs_skip_level", 32'(level), 32'd0);
        send(16'h0000, 1'b0);
        send(16'h3C00, 1'b1);
        chk("zs_level", 32'(level),    32'd1);
        chk("zs_a",     32'(out_a),    32'h0000);
        chk("zs_b",     32'(out_b),    32'h3C00);
        chk("zs_clr",   32'(out_clr),  32'd1);
        chk("zs_last",  32'(out_last), 32'd1);
`else
        chk("zs_keep_level", 32'(level), 32'd1);
        send(16'h0000, 1'b0);
        send(16'h3C00, 1'b1);
        chk("zs_level", 32'(level),    32'd2);
        chk("zs0_b",    32'(out_b),    32'h4000);
        chk("zs0_clr",  32'(out_clr),  32'd1);
        chk("zs0_last", 32'(out_last), 32'd0);
        out_ready = 1'b1;
        tick(1);
        chk("zs1_b",    32'(out_b),    32'h3C00);
        chk("zs1_clr",  32'(out_clr),  32'd0);
        chk("zs1_last", 32'(out_last), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/dlfloat_operand_loader.md
DLFLOAT_OPERAND_LOADER -- requirements
Module: dlfloat_operand_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of operand pairs the FIFO holds (power of 2, minimum 2).
REQ-002 The block SHALL have port clk  input  1  the single clock; all logic updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_data  input  16  DLFloat16 operand word; words arrive A first, then B.
REQ-005 The block SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-006 The block SHALL have port in_ready  output  1  the block accepts in_data this cycle.
REQ-007 The block SHALL have port in_last  input  1  sampled with a B word; marks the last pair of a dot product.
REQ-008 The block SHALL have ports out_a and out_b  output  16 each  operand pair at the FIFO head.
REQ-009 The block SHALL have port out_valid  output  1  a pair is presented.
REQ-010 The block SHALL have port out_ready  input  1  the MAC consumes the presented pair.
REQ-011 The block SHALL have port out_clr  output  1  the head pair is the first pair of a new accumulation.
REQ-012 The block SHALL have port out_last  output  1  the head pair ends an accumulation.
REQ-013 The block SHALL have port level  output  clog2(DEPTH)+1  number of pairs stored in the FIFO.
REQ-014 The block SHALL have port err_odd  output  1  sticky flag: in_last was asserted with an A word.

Function
REQ-015 A word SHALL be accepted only in a cycle where in_valid and in_ready are both high.
REQ-016 The phase FSM SHALL have two states. S_A: an accepted word loads the hold register and moves to S_B. S_B: an accepted word is pushed into the FIFO with the hold register as {a, b=in_data, last=in_last, clr=clr_pend}, then returns to S_A.
REQ-017 in_ready SHALL be 1 in S_A. In S_B it SHALL be !full, with full taken from the registered level; a pop in the same cycle does not free space.
REQ-018 The FIFO SHALL be first-word-fall-through. out_valid = (level != 0). out_a, out_b, out_clr and out_last SHALL come from the head entry and be 0 when the FIFO is empty.
REQ-019 Latency: a B word accepted at edge N SHALL show out_valid=1 with that pair after edge N, provided the FIFO was empty.
REQ-020 A pop SHALL occur when out_valid and out_ready are both high.
REQ-021 On a push together with a pop, level SHALL be unchanged; push only adds 1; pop only subtracts 1.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH.
REQ-023 Outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 clr_pend SHALL be set to 1 by reset and by any push with last=1. Any push with last=0 SHALL clear it.
REQ-025 in_last on an accepted A word SHALL be ignored for tagging and SHALL set err_odd. err_odd SHALL be cleared only by reset.
REQ-026 in_data SHALL be passed through bit-exact; no arithmetic is performed on operand values.

Reset
REQ-027 While rst_n=0, the block SHALL immediately force: FSM to S_A; pointers and level to 0; hold register to 0; clr_pend to 1; err_odd to 0.
REQ-028 Resulting output values during reset SHALL be: in_ready=1, out_valid=0, out_a=out_b=0, out_clr=out_last=0.
REQ-029 A reset between an A word and its B word SHALL discard the held A word. The FIFO contents SHALL be lost.

Configuration
REQ-030 With DLF_ZERO_SKIP_EN defined, a completed pair with a==16'h0000 or b==16'h0000 and last=0 SHALL NOT be pushed. clr_pend SHALL be unchanged and in_ready behaviour SHALL be unchanged.
REQ-031 With DLF_ZERO_SKIP_EN defined, a zero pair with last=1 SHALL still be pushed, so the accumulation boundary is preserved.
REQ-032 Without DLF_ZERO_SKIP_EN, every completed pair SHALL be pushed.

Verification
REQ-033 Basic pair: with out_ready=1, drive A=16'h3E00, then B=16'h4000 with in_last=1. Required: one cycle after B, out_a=3E00, out_b=4000, out_clr=1, out_last=1, level=1.
REQ-034 Fill and backpressure: hold out_ready=0 and drive 10 words. Required: level reaches 4 and in_ready=0 in S_B; the 5th pair is held. Then set out_ready=1. Required: pairs come out in order with no loss or duplication, and the pointers wrap.
REQ-035 Simultaneous push/pop: start at level=2, accept a B word and pop in the same cycle. Required: level stays 2.
REQ-036 Clear tagging: send 3 pairs with last=0,0,1, then 1 pair with last=0. Required: out_clr=1,0,0,1 and out_last=0,0,1,0.
REQ-037 Odd last / reset mid-pair: assert in_last on an A word, then assert rst_n=0 before B arrives. Required: err_odd=1 until reset; after reset the next word is treated as A.
REQ-038 Zero skip: with DLF_ZERO_SKIP_EN defined, send pairs (0000,4000,last=0) and (0000,3C00,last=1). Required: only the second pair is output, with out_clr=1 and out_last=1. Without the macro, both pairs are output.
